// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit.
// Handshakes one load/store per instruction with dmem and stalls the pipe.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_aluc,
  input  logic [31:0] MEM_rt_reg,
  input  logic [3:0]  MEM_mem_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MEM_DMEM,
  output logic        mem_stall,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_n;
  logic        is_word, is_half, is_byte;
  logic        is_load, is_store;
  logic        aligned, go, bad;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [3:0]  lat_op;
  logic [1:0]  lat_lane;
  logic        lat_load;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_data;

  // Decode access size and direction; codes 0 and 9-15 are no access.
  always_comb begin
    is_word  = 1'b0;
    is_half  = 1'b0;
    is_byte  = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    unique case (MEM_mem_op)
      4'd1: begin is_word = 1'b1; is_load  = 1'b1; end
      4'd2,
      4'd3: begin is_half = 1'b1; is_load  = 1'b1; end
      4'd4,
      4'd5: begin is_byte = 1'b1; is_load  = 1'b1; end
      4'd6: begin is_word = 1'b1; is_store = 1'b1; end
      4'd7: begin is_half = 1'b1; is_store = 1'b1; end
      4'd8: begin is_byte = 1'b1; is_store = 1'b1; end
      default: ;
    endcase
  end

  // Alignment check plus lane-replicated store data and byte enables.
  always_comb begin
    aligned = 1'b1;
    st_data = {4{MEM_rt_reg[7:0]}};
    st_be   = 4'b0001 << MEM_aluc[1:0];
    unique case (1'b1)
      is_word: begin
        aligned = (MEM_aluc[1:0] == 2'b00);
        st_data = MEM_rt_reg;
        st_be   = 4'b1111;
      end
      is_half: begin
        aligned = ~MEM_aluc[0];
        st_data = {2{MEM_rt_reg[15:0]}};
        st_be   = MEM_aluc[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    go  = (is_load | is_store) & aligned;
    bad = (is_load | is_store) & ~aligned;
  end

  // Lane select and extension of the returned read word.
  always_comb begin
    ld_half = lat_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_byte = 8'(dmem_rdata >> {lat_lane, 3'b000});
    unique case (lat_op)
      4'd2:    ld_data = {{16{ld_half[15]}}, ld_half};
      4'd3:    ld_data = {16'h0000, ld_half};
      4'd4:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      4'd5:    ld_data = {24'h000000, ld_byte};
      default: ld_data = dmem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and the combinational stall.
  always_comb begin
    state_n   = state;
    mem_stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          mem_stall = 1'b1;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dmem_ack) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered bus outputs, load result and fault pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      MEM_DMEM   <= '0;
      misalign   <= 1'b0;
      lat_op     <= '0;
      lat_lane   <= '0;
      lat_load   <= 1'b0;
    end else begin
      misalign <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {MEM_aluc[31:2], 2'b00};
            dmem_wdata <= st_data;
            dmem_be    <= st_be;
            lat_op     <= MEM_mem_op;
            lat_lane   <= MEM_aluc[1:0];
            lat_load   <= is_load;
          end else if (bad) begin
            misalign <= 1'b1;
            if (is_load) MEM_DMEM <= '0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (lat_load) MEM_DMEM <= ld_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit.
// Directed table, hand sequences and a randomized run against a model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MEM_aluc, MEM_rt_reg;
  logic [3:0]  MEM_mem_op;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] MEM_DMEM;
  logic        mem_stall, misalign;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_dmem;
  logic [31:0] cap_be, cap_wdata;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .MEM_aluc(MEM_aluc), .MEM_rt_reg(MEM_rt_reg),
    .MEM_mem_op(MEM_mem_op),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .MEM_DMEM(MEM_DMEM),
    .mem_stall(mem_stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: access size in bytes, 0 for no access.
  function automatic int op_size(input logic [3:0] op);
    if (op == 1 || op == 6) return 4;
    if (op == 2 || op == 3 || op == 7) return 2;
    if (op == 4 || op == 5 || op == 8) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    sh = int'(a % 4) * 8;
    case (op)
      4'd1: return rd;
      4'd2, 4'd3: begin
        v = (rd >> sh) & 32'h0000FFFF;
        if (op == 2 && v >= 32'h8000) v = v + 32'hFFFF0000;
        return v;
      end
      default: begin
        v = (rd >> sh) & 32'h000000FF;
        if (op == 4 && v >= 32'h80) v = v + 32'hFFFFFF00;
        return v;
      end
    endcase
  endfunction

  function automatic logic [31:0] ref_be(input int sz,
                                         input logic [31:0] a);
    if (sz == 4) return 32'd15;
    if (sz == 2) return 32'd3 << (a % 4);
    return 32'd1 << (a % 4);
  endfunction

  function automatic logic [31:0] ref_wdata(input int sz,
                                            input logic [31:0] rt);
    if (sz == 4) return rt;
    if (sz == 2) return (rt % 65536) * 32'h00010001;
    return (rt % 256) * 32'h01010101;
  endfunction

  // One complete access; when b2b is set it returns in the DONE cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
      input logic [31:0] rt, input logic [31:0] rd, input int waits,
      input bit ack_idle, input bit b2b);
    int sz;
    bit ld, st;
    sz = op_size(op);
    ld = (op >= 1 && op <= 5);
    st = (op >= 6 && op <= 8);
    @(negedge clk);
    MEM_mem_op = op;
    MEM_aluc   = a;
    MEM_rt_reg = rt;
    if (sz == 0) begin
      dmem_ack = ack_idle;
      #1 chk("none_stall", 32'(mem_stall), 0);
      @(posedge clk); #1;
      chk("none_req", 32'(dmem_req), 0);
      chk("none_mis", 32'(misalign), 0);
      chk("none_hold", MEM_DMEM, exp_dmem);
      dmem_ack = 1'b0;
    end else if (a % sz != 0) begin
      dmem_ack = ack_idle;
      #1 chk("mis_stall", 32'(mem_stall), 0);
      @(posedge clk); #1;
      chk("mis_req", 32'(dmem_req), 0);
      chk("mis_pulse", 32'(misalign), 1);
      if (ld) exp_dmem = 0;
      chk("mis_dmem", MEM_DMEM, exp_dmem);
      @(negedge clk);
      MEM_mem_op = 4'd0;
      dmem_ack = 1'b0;
      @(posedge clk); #1;
      chk("mis_pulse_end", 32'(misalign), 0);
    end else begin
      #1 chk("idle_stall", 32'(mem_stall), 1);
      @(posedge clk); #1;
      chk("busy_req", 32'(dmem_req), 1);
      chk("busy_stall", 32'(mem_stall), 1);
      chk("busy_we", 32'(dmem_we), 32'(st));
      chk("busy_addr", dmem_addr, a - (a % 4));
      chk("busy_be", 32'(dmem_be), ref_be(sz, a));
      if (st) chk("busy_wdata", dmem_wdata, ref_wdata(sz, rt));
      cap_be    = 32'(dmem_be);
      cap_wdata = dmem_wdata;
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("wait_stall", 32'(mem_stall), 1);
        chk("wait_req", 32'(dmem_req), 1);
        chk("wait_addr", dmem_addr, a - (a % 4));
        chk("wait_be", 32'(dmem_be), cap_be);
      end
      @(negedge clk);
      dmem_ack   = 1'b1;
      dmem_rdata = rd;
      @(posedge clk); #1;
      chk("done_req", 32'(dmem_req), 0);
      chk("done_stall", 32'(mem_stall), 0);
      if (ld) exp_dmem = ref_load(op, a, rd);
      chk("done_dmem", MEM_DMEM, exp_dmem);
      if (!b2b) begin
        @(negedge clk);
        dmem_ack   = 1'b0;
        MEM_mem_op = 4'd0;
        @(posedge clk); #1;
        chk("back_idle", 32'(mem_stall), 0);
        chk("back_req", 32'(dmem_req), 0);
      end
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, rt, rd;
    int          waits;
    logic [31:0] dmem, be, wdata;
    bit          bus;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'd1, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                32'hDEADBEEF, 32'hF, 32'h0, 1'b1};
    vecs[1] = '{4'd4, 32'h103, 32'h0, 32'h80FF1234, 1,
                32'hFFFFFF80, 32'h8, 32'h0, 1'b1};
    vecs[2] = '{4'd5, 32'h103, 32'h0, 32'h80FF1234, 0,
                32'h00000080, 32'h8, 32'h0, 1'b1};
    vecs[3] = '{4'd2, 32'h102, 32'h0, 32'h80FF1234, 2,
                32'hFFFF80FF, 32'hC, 32'h0, 1'b1};
    vecs[4] = '{4'd7, 32'h106, 32'h0000ABCD, 32'h0, 3,
                32'hFFFF80FF, 32'hC, 32'hABCDABCD, 1'b1};
    vecs[5] = '{4'd1, 32'h102, 32'h0, 32'h0, 0,
                32'h0, 32'h0, 32'h0, 1'b0};
    vecs[6] = '{4'd3, 32'h100, 32'h0, 32'h1234F00D, 0,
                32'h0000F00D, 32'h3, 32'h0, 1'b1};
    vecs[7] = '{4'd6, 32'h200, 32'hCAFEBABE, 32'h0, 1,
                32'h0000F00D, 32'hF, 32'hCAFEBABE, 1'b1};
    vecs[8] = '{4'd12, 32'h300, 32'h0, 32'h0, 0,
                32'h0000F00D, 32'h0, 32'h0, 1'b0};

    rst = 1'b1;
    MEM_aluc = '0; MEM_rt_reg = '0; MEM_mem_op = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    exp_dmem = '0;
    #12;
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_we", 32'(dmem_we), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", 32'(dmem_be), 0);
    chk("rst_dmem", MEM_DMEM, 0);
    chk("rst_mis", 32'(misalign), 0);
    chk("rst_stall", 32'(mem_stall), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].rt, vecs[i].rd,
             vecs[i].waits, 1'b0, 1'b0);
      chk("tbl_dmem", MEM_DMEM, vecs[i].dmem);
      if (vecs[i].bus) begin
        chk("tbl_be", cap_be, vecs[i].be);
        if (vecs[i].op >= 6) chk("tbl_wdata", cap_wdata, vecs[i].wdata);
      end
    end

    // Back-to-back LW 0x0 then SB 0x5.
    run_op(4'd1, 32'h0, 32'h0, 32'h11223344, 0, 1'b0, 1'b1);
    @(negedge clk);
    dmem_ack   = 1'b0;
    MEM_mem_op = 4'd8;
    MEM_aluc   = 32'h5;
    MEM_rt_reg = 32'h77;
    #1 chk("b2b_done_stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    chk("b2b_idle_stall", 32'(mem_stall), 1);
    chk("b2b_idle_req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    chk("b2b_req", 32'(dmem_req), 1);
    chk("b2b_be", 32'(dmem_be), 32'h2);
    chk("b2b_wdata", dmem_wdata, 32'h77777777);
    chk("b2b_addr", dmem_addr, 32'h4);
    @(negedge clk);
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    chk("b2b_done", 32'(dmem_req), 0);
    chk("b2b_dmem", MEM_DMEM, 32'h11223344);
    @(negedge clk);
    dmem_ack = 1'b0;
    MEM_mem_op = 4'd0;
    @(posedge clk); #1;

    // Reset in BUSY of an SW, then a late ack.
    @(negedge clk);
    MEM_mem_op = 4'd6;
    MEM_aluc   = 32'h40;
    MEM_rt_reg = 32'h12345678;
    @(posedge clk); #1;
    chk("rb_req", 32'(dmem_req), 1);
    @(negedge clk);
    MEM_mem_op = 4'd0;
    rst = 1'b1;
    #1;
    chk("rb_req_async", 32'(dmem_req), 0);
    chk("rb_we", 32'(dmem_we), 0);
    chk("rb_addr", dmem_addr, 0);
    chk("rb_wdata", dmem_wdata, 0);
    chk("rb_be", 32'(dmem_be), 0);
    chk("rb_dmem", MEM_DMEM, 0);
    chk("rb_stall", 32'(mem_stall), 0);
    exp_dmem = '0;
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    chk("rb_ack_ign_req", 32'(dmem_req), 0);
    chk("rb_ack_ign_stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    chk("rb_idle_dmem", MEM_DMEM, 0);
    @(negedge clk);
    dmem_ack = 1'b0;

    // Randomized run against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic [3:0]  op;
      logic [31:0] a;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      run_op(op, a, $urandom, $urandom, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-002 The block SHALL have these inputs from the EX/MEM register: MEM_aluc  input  32  effective byte address; MEM_rt_reg  input  32  store data; MEM_mem_op  input  4  access type.
REQ-003 The block SHALL have these data-memory ports: dmem_req  output  1  request; dmem_we  output  1  write; dmem_addr  output  32  word address; dmem_wdata  output  32  lane-aligned write data; dmem_be  output  4  byte enables; dmem_ack  input  1  completion; dmem_rdata  input  32  read word.
REQ-004 The block SHALL have these pipeline ports: MEM_DMEM  output  32  extended load result, feeding the MEM/WB register; mem_stall  output  1  freeze upstream stages and hold MEM/WB (W_ena = !mem_stall); misalign  output  1  one-cycle alignment-fault pulse.
REQ-005 MEM_mem_op SHALL use this encoding: 0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; codes 9-15 SHALL be treated as none.

Function
REQ-006 FSM states SHALL be IDLE, BUSY and DONE.
REQ-007 An access is "aligned" when: word ops have MEM_aluc[1:0]==0; halfword ops have MEM_aluc[0]==0; byte ops are always aligned.
REQ-008 In IDLE with an aligned access present: mem_stall SHALL be 1 combinationally; on the next edge, latch addr/op/data, drive dmem_req=1 and enter BUSY.
REQ-009 In BUSY: mem_stall=1; dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL stay stable until the cycle dmem_ack=1 is sampled.
REQ-010 On the edge where BUSY samples dmem_ack=1: drop dmem_req, register the load result into MEM_DMEM (loads only) and enter DONE.
REQ-011 In DONE: mem_stall=0 so the pipeline advances; the next edge SHALL return to IDLE unconditionally. A back-to-back access is therefore seen in IDLE one cycle later.
REQ-012 Minimum latency SHALL be 3 cycles (IDLE, BUSY with ack, DONE); each extra wait cycle without ack adds one cycle.
REQ-013 dmem_addr SHALL be {addr[31:2],2'b00}; dmem_we=1 for ops 6-8.
REQ-014 Byte enables SHALL be little-endian: word 4'b1111; half 4'b0011 << addr[1]*2; byte 4'b0001 << addr[1:0].
REQ-015 Store data SHALL be replicated to the lanes: SW as-is; SH {2{rt[15:0]}}; SB {4{rt[7:0]}}.
REQ-016 Load extraction SHALL select the lane by addr[1:0]; LH and LB sign-extend, LHU and LBU zero-extend, LW takes the word as-is.
REQ-017 A misaligned access in IDLE SHALL issue no request and hold mem_stall=0; misalign SHALL be 1 for one cycle, registered on the next edge; MEM_DMEM SHALL be cleared to 0 for a misaligned load.
REQ-018 For none/illegal ops, and for stores, MEM_DMEM SHALL hold its previous value.
REQ-019 dmem_ack outside BUSY SHALL be ignored.
REQ-020 All outputs except mem_stall SHALL be registered.

Reset
REQ-021 rst SHALL force state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, MEM_DMEM=0 and misalign=0; mem_stall then reflects only the current inputs.
REQ-022 Reset asserted in BUSY SHALL abandon the access immediately (dmem_req=0 asynchronously); an ack arriving after reset SHALL be ignored.

Verification
REQ-023 LW 0x100, ack on the first BUSY cycle, rdata=0xDEADBEEF -> mem_stall 1,1,0; MEM_DMEM=0xDEADBEEF in DONE; dmem_be=4'b1111.
REQ-024 LB 0x103 with rdata=0x80FF1234 -> MEM_DMEM=0xFFFFFF80; LBU same -> 0x00000080; LH 0x102 -> 0xFFFF80FF.
REQ-025 SH 0x106 with rt=0x0000ABCD -> dmem_addr=0x104, be=4'b1100, wdata=0xABCDABCD, we=1; 3 ack wait cycles -> mem_stall high for 5 cycles, then DONE.
REQ-026 LW 0x102 -> no dmem_req, mem_stall=0, misalign pulse for one cycle, MEM_DMEM=0.
REQ-027 rst pulsed during BUSY of an SW, then ack=1 -> dmem_req=0 at once, state IDLE, no DONE cycle, outputs at reset values.
REQ-028 Back-to-back LW 0x0 and SB 0x5 (rt=0x77) -> second request starts the cycle after DONE; be=4'b0010, wdata=0x77777777.
